// File: rtl/argmax_classifier.sv
// argmax_classifier: captures a signed vector when inputs_ready rises. It then
// scans the vector one element per clock to find the largest value and its
// index. The result is held with output_ready until the next capture.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-high
//   inputs_ready - level from the upstream layer; its rising edge triggers a capture
//   inputs       - NUM_INPUTS signed elements of DATA_WIDTH bits
//   class_index  - index of the maximum element (lowest index wins ties)
//   max_value    - value of the maximum element
//   output_ready - result valid; held until the next capture
//   busy         - high while scanning
module argmax_classifier #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 10,
  localparam int unsigned INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inputs_ready,
  input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
  output logic        [INDEX_WIDTH-1:0] class_index,
  output logic signed [DATA_WIDTH-1:0] max_value,
  output logic                         output_ready,
  output logic                         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                        r_state;
  logic                          r_prev_ready;
  logic signed [DATA_WIDTH-1:0]  r_buffer [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  r_best_value;
  logic        [INDEX_WIDTH-1:0] r_best_index;
  logic        [INDEX_WIDTH-1:0] r_scan_index;

  logic                          w_rise;
  logic signed [DATA_WIDTH-1:0]  w_scan_value;
  logic                          w_take;
  logic                          w_last;
  logic signed [DATA_WIDTH-1:0]  w_next_value;
  logic        [INDEX_WIDTH-1:0] w_next_index;

  // A level held high yields one trigger; prev is cleared by reset so a
  // high level at reset release counts as a rise.
  assign w_rise = inputs_ready & ~r_prev_ready;

  // Element under examination; a one-element build never scans.
  if (NUM_INPUTS > 1) begin : g_scan
    assign w_scan_value = r_buffer[r_scan_index];
  end else begin : g_single
    assign w_scan_value = r_buffer[0];
  end

  // Strict compare keeps the lowest index among equal maxima.
  assign w_take       = w_scan_value > r_best_value;
  assign w_next_value = w_take ? w_scan_value : r_best_value;
  assign w_next_index = w_take ? r_scan_index : r_best_index;
  assign w_last       = (r_scan_index == INDEX_WIDTH'(NUM_INPUTS - 1));

  // Capture / scan / hold state machine with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prev_ready <= 1'b0;
      r_best_value <= '0;
      r_best_index <= '0;
      r_scan_index <= '0;
      class_index  <= '0;
      max_value    <= '0;
      output_ready <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        r_buffer[i] <= '0;
      end
    end else begin
      r_prev_ready <= inputs_ready;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_rise) begin
            r_buffer <= inputs;
            if (NUM_INPUTS == 1) begin
              // Nothing to compare: publish on the capture edge itself.
              class_index  <= '0;
              max_value    <= inputs[0];
              output_ready <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_best_value <= inputs[0];
              r_best_index <= '0;
              r_scan_index <= INDEX_WIDTH'(1);
              output_ready <= 1'b0;
              busy         <= 1'b1;
              r_state      <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          // Rises during the scan are ignored; the buffer stays frozen.
          if (w_last) begin
            class_index  <= w_next_index;
            max_value    <= w_next_value;
            output_ready <= 1'b1;
            busy         <= 1'b0;
            r_state      <= ST_DONE;
          end else begin
            r_best_value <= w_next_value;
            r_best_index <= w_next_index;
            r_scan_index <= r_scan_index + INDEX_WIDTH'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
